// File: rtl/apb_mst_pkg.sv
// Shared types for the APB SFR master: FSM state encoding and the latched command.
package apb_mst_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic [1:0] ST_RESP   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } apb_mst_st_e;

  // Command field widths; the master's AW/DW parameters must not exceed these.
  localparam int CMD_AW = 12;
  localparam int CMD_DW = 32;
  localparam int CMD_SW = CMD_DW / 8;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [CMD_SW-1:0] strb;
    logic [2:0]        prot;
  } apb_cmd_t;

endpackage

// File: rtl/apbif.sv
// APB3/APB4 bus bundle shared by initiators and SFR register blocks.
interface apbif #(
  parameter int PAW = 12,
  parameter int DW  = 32
);
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [PAW-1:0]  paddr;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic            apbactive;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot, apbactive,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase watchdog: counts pready-low cycles and flags expiry on the TMO-th one.
module apb_mst_wdog #(
  parameter int TMO = 256
) (
  input  logic pclk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            CW   = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] LAST = (TMO > 0) ? CW'(TMO - 1) : '0;

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // TMO == 0 ties the watchdog off; a pready in the expiry cycle drops inc and wins.
  assign expired = (TMO != 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/apb_sfr_master.sv
// Single-outstanding APB initiator: valid/ready command in, APB transfer out, valid/ready response back.
module apb_sfr_master
  import apb_mst_pkg::*;
#(
  parameter int AW  = CMD_AW,
  parameter int DW  = CMD_DW,
  parameter int TMO = 256
) (
  input  logic            pclk,
  input  logic            reset,
  apbif.master            apbmaster,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_strb,
  input  logic [2:0]      cmd_prot,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_tmo,
  output logic            busy
);

  apb_mst_st_e   state_q;
  apb_cmd_t      cmd_q, cmd_d;
  logic          psel_q, penable_q;
  logic          rsp_valid_q, rsp_err_q, rsp_tmo_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          tmo_expired;

  always_comb begin
    cmd_d       = '0;
    cmd_d.write = cmd_write;
    cmd_d.addr  = CMD_AW'(cmd_addr);
    cmd_d.wdata = CMD_DW'(cmd_wdata);
    cmd_d.strb  = cmd_write ? CMD_SW'(cmd_strb) : '0;
    cmd_d.prot  = cmd_prot;
  end

  apb_mst_wdog #(.TMO(TMO)) u_wdog (
    .pclk    (pclk),
    .reset   (reset),
    .clr     (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !apbmaster.pready),
    .expired (tmo_expired)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q   <= cmd_d;
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apbmaster.pready) begin
            rsp_rdata_q <= cmd_q.write ? '0 : apbmaster.prdata;
            rsp_err_q   <= apbmaster.pslverr;
            rsp_tmo_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end else if (tmo_expired) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_tmo_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  // Bus fields come straight from the command latch, so they hold between transfers.
  assign apbmaster.psel      = psel_q;
  assign apbmaster.penable   = penable_q;
  assign apbmaster.apbactive = psel_q;
  assign apbmaster.pwrite    = cmd_q.write;
  assign apbmaster.paddr     = cmd_q.addr[AW-1:0];
  assign apbmaster.pwdata    = cmd_q.wdata[DW-1:0];
  assign apbmaster.pstrb     = cmd_q.strb[DW/8-1:0];
  assign apbmaster.pprot     = cmd_q.prot;

  // NOTE: cmd_ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_apb_sfr_master.sv
// Directed bench for apb_sfr_master with TMO=8 and a small bus-functional APB slave.
module tb_apb_sfr_master;

  logic        pclk  = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo, busy;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] cr_model = 32'h0;
  logic [31:0] sr_val   = 32'h0000_1234;

  always #5 pclk = ~pclk;

  apbif #(.PAW(12), .DW(32)) bus ();

  apb_sfr_master #(.AW(12), .DW(32), .TMO(8)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .apbmaster (bus),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_tmo   (rsp_tmo),
    .busy      (busy)
  );

  // Control register at 0x10, status register at 0x14, everything else returns 0xDEAD.
  always @(posedge pclk) begin
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && bus.paddr == 12'h010)
      cr_model <= bus.pwdata;
  end

  always_comb begin
    case (bus.paddr)
      12'h010: bus.prdata = cr_model;
      12'h014: bus.prdata = sr_val;
      default: bus.prdata = 32'h0000_DEAD;
    endcase
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_acc;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_strb    = '0;
    cmd_prot    = '0;
    rsp_ready   = 1'b1;
    bus.pready  = 1'b1;
    bus.pslverr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write to the control register
    issue(1'b1, 12'h010, 32'h0000_00A5, 4'hF, 3'b010);
    chk("wr_setup_psel", 32'(bus.psel), 32'd1);
    chk("wr_setup_penable", 32'(bus.penable), 32'd0);
    chk("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("wr_setup_apbactive", 32'(bus.apbactive), 32'd1);
    chk("wr_paddr", 32'(bus.paddr), 32'h010);
    chk("wr_pwdata", bus.pwdata, 32'h0000_00A5);
    chk("wr_pstrb", 32'(bus.pstrb), 32'hF);
    chk("wr_pprot", 32'(bus.pprot), 32'd2);
    chk("wr_pwrite", 32'(bus.pwrite), 32'd1);
    tick();
    chk("wr_access_penable", 32'(bus.penable), 32'd1);
    chk("wr_access_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_tmo", 32'(rsp_tmo), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_resp_psel", 32'(bus.psel), 32'd0);
    chk("wr_resp_apbactive", 32'(bus.apbactive), 32'd0);
    tick();
    chk("wr_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wr_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("cr_written", cr_model, 32'h0000_00A5);
    chk("idle_paddr_held", 32'(bus.paddr), 32'h010);

    // Read back the control register
    issue(1'b0, 12'h010, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("cr_rb_rdata", rsp_rdata, 32'h0000_00A5);
    tick();

    // Read the status register; strobes forced low
    issue(1'b0, 12'h014, 32'hFFFF_FFFF, 4'hF, 3'b000);
    chk("rd_setup_pstrb", 32'(bus.pstrb), 32'd0);
    chk("rd_pwrite", 32'(bus.pwrite), 32'd0);
    tick();
    chk("rd_access_pstrb", 32'(bus.pstrb), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // Three wait states: ACCESS spans four cycles, response at N+6
    bus.pready = 1'b0;
    issue(1'b1, 12'h018, 32'hCAFE_F00D, 4'h3, 3'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_penable", 32'(bus.penable), 32'd1);
      chk("ws_paddr", 32'(bus.paddr), 32'h018);
      chk("ws_pwdata", bus.pwdata, 32'hCAFE_F00D);
      chk("ws_rsp_valid", 32'(rsp_valid), 32'd0);
      if (i == 3) bus.pready = 1'b1;
    end
    tick();
    chk("ws_rsp_valid_n6", 32'(rsp_valid), 32'd1);
    chk("ws_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // pready stuck low: watchdog ends ACCESS after exactly 8 cycles
    bus.pready = 1'b0;
    issue(1'b0, 12'h01C, 32'h0, 4'h0, 3'b000);
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.penable) break;
      n_acc++;
    end
    chk("tmo_access_cycles", 32'(n_acc), 32'd8);
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_rsp_tmo", 32'(rsp_tmo), 32'd1);
    chk("tmo_rsp_rdata", rsp_rdata, 32'd0);
    chk("tmo_resp_psel", 32'(bus.psel), 32'd0);
    bus.pready = 1'b1;
    tick();
    chk("tmo_late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("tmo_late_psel", 32'(bus.psel), 32'd0);
    chk("tmo_late_busy", 32'(busy), 32'd0);

    // Slave error on a read, response held for five cycles by backpressure
    bus.pslverr = 1'b1;
    rsp_ready   = 1'b0;
    issue(1'b0, 12'h020, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(rsp_err), 32'd1);
    chk("err_rsp_tmo", 32'(rsp_tmo), 32'd0);
    chk("err_rsp_rdata", rsp_rdata, 32'h0000_DEAD);
    bus.pslverr = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 12'h014;
    cmd_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0000_DEAD);
      chk("hold_rsp_err", 32'(rsp_err), 32'd1);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_psel", 32'(bus.psel), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("hold_release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_release_psel", 32'(bus.psel), 32'd0);

    // Reset during ACCESS aborts the transfer without a response
    bus.pready = 1'b0;
    issue(1'b0, 12'h014, 32'h0, 4'h0, 3'b000);
    tick();
    chk("mid_access_penable", 32'(bus.penable), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_psel", 32'(bus.psel), 32'd0);
    chk("mid_rst_penable", 32'(bus.penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset      = 1'b0;
    bus.pready = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    issue(1'b0, 12'h014, 32'h0, 4'h0, 3'b000);
    tick();
    tick();
    chk("post_abort_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post_abort_rdata", rsp_rdata, 32'h0000_1234);
    chk("post_abort_err", 32'(rsp_err), 32'd0);
    chk("post_abort_tmo", 32'(rsp_tmo), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_sfr_master.md
# apb_sfr_master

APB initiator that converts a simple valid/ready command stream into single APB3/APB4 transfers on an `apbif` master port. It returns read data and error status on a valid/ready response stream. It is the bus-side counterpart of the SFR register blocks (`apb_cr`/`apb_sr`/`apb_fr`/`apb_ar`): it drives a local APB segment from a sequencer or bridge so those registers can be exercised and accessed. It supports one outstanding transfer, with a watchdog on `pready`.

## Interface
Parameters:
- `AW`, 12: APB address width; matches the `PAW` of the connected `apbif`.
- `DW`, 32: data width.
- `TMO`, 256: maximum ACCESS-phase cycles to wait for `pready`. 0 disables the watchdog.

Ports:
- `pclk`  in  1: clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `apbmaster`  `apbif.master`  -: APB bus. Drives `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`, `apbactive`. Samples `prdata`, `pready`, `pslverr`.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1: 1 selects write, 0 selects read.
- `cmd_addr`  in  AW: byte address.
- `cmd_wdata`  in  DW: write data.
- `cmd_strb`  in  DW/8: write strobes. Forced to 0 on reads.
- `cmd_prot`  in  3: passed through to `pprot`.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  DW: read data. 0 for writes, errors and timeouts.
- `rsp_err`  out  1: `pslverr` sampled high, or timeout.
- `rsp_tmo`  out  1: this response was caused by a timeout.
- `busy`  out  1: state is not IDLE.

## Operation
- The FSM has four states:
  - IDLE: `cmd_ready`=1. On handshake, latch write/addr/wdata/strb/prot, then go to SETUP.
  - SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
  - ACCESS: `psel`=1, `penable`=1. Remain while `pready`=0 and the watchdog has not expired.
    - On `pready`=1: capture `prdata` (reads only) and `pslverr` into the response registers, then go to RESP.
    - On watchdog expiry: set `rsp_err`=1, `rsp_tmo`=1, `rsp_rdata`=0, then go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- APB outputs are registered. `paddr`/`pwrite`/`pwdata`/`pstrb`/`pprot` are held stable from SETUP through the last ACCESS cycle.
- Outside SETUP and ACCESS, `psel`=`penable`=0 and the other bus outputs hold their last value.
- `apbactive` = 1 in SETUP and ACCESS.
- Watchdog: counter cleared on entry to ACCESS, incremented each ACCESS cycle with `pready`=0. Expiry occurs when count == TMO-1 and `pready`=0. A `pready` in the expiry cycle wins, so the transfer completes normally.
- Timeout abort: `psel`/`penable` drop the cycle after expiry. The transfer is abandoned, and a late `pready` is ignored.
- Reset values: all outputs 0; `cmd_ready`=1 from the first cycle after reset release; state IDLE; counter 0.
- Reset mid-transfer: the bus is released on the next edge, and no response is produced for the aborted command.
- `cmd_ready` is 0 in SETUP, ACCESS and RESP. A command held valid across these states is not accepted until IDLE.

## Timing
- Zero-wait-state slave:
  - handshake at edge N;
  - SETUP in cycle N+1;
  - ACCESS in cycle N+2 (completes);
  - `rsp_valid` in cycle N+3.
- Each `pready`=0 cycle adds one cycle to the latency.
- Throughput with `rsp_ready` tied high is one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- `rsp_*` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Watchdog: with `pready` never asserted, ACCESS lasts exactly TMO cycles, then RESP follows.

## Structure
- Package `apb_mst_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_st_e`;
  - `localparam` state encodings;
  - `typedef struct packed` for the latched command (write, addr, wdata, strb, prot).
- One sub-module, `apb_mst_wdog`: a parameterised cycle counter with inputs `clr`/`inc` and output `expired`. It is tied off to never expire when `TMO`=0.
- Top level: FSM, command latch, response registers and `apbif` drive.

## Test plan
- Write of 0x0000_00A5 to 0x10 with strb 0xF against an `apb_cr` at 0x10, `rsp_ready` high → `psel` rises at N+1, `penable` at N+2; `rsp_valid` at N+3 with `rsp_err`=0; `cr` reads back 0x00A5.
- Read of 0x14 with `apb_sr` driving `sr`=0x1234 → `rsp_rdata`=0x0000_1234, `rsp_err`=0, `pstrb`=0 throughout.
- Slave inserts 3 wait states → ACCESS lasts 4 cycles; `paddr`/`pwdata` constant; response at N+6.
- `pready` stuck low, TMO=8 → ACCESS exactly 8 cycles; `rsp_err`=1, `rsp_tmo`=1, `rsp_rdata`=0; `psel`=0 in RESP.
- `pslverr`=1 on a read returning 0xDEAD → `rsp_err`=1, `rsp_tmo`=0, `rsp_rdata`=0xDEAD. Holding `rsp_ready` low for 5 cycles keeps the response stable and `cmd_ready`=0.
- Assert `reset` during ACCESS → next edge `psel`=`penable`=`rsp_valid`=0 and `cmd_ready`=1; a new read completes normally afterward.
